// File: rtl/error_tracker_ctrl_pkg.sv
// error_tracker_ctrl_pkg: shared types and limits for the error_tracker trigger controller
package error_tracker_ctrl_pkg;
  typedef enum logic [1:0] {OFF = 2'b00, ANY_ERR = 2'b01, THRESH = 2'b10, PERIODIC = 2'b11} trig_mode_t;
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, HOLDOFF = 2'b10, DONE = 2'b11} trig_state_t;
  localparam int MIN_HOLDOFF = 4;
  localparam int MIN_PERIOD = 5;
  localparam int STORE_BURST = 4;
endpackage

// File: rtl/errt_popcount.sv
// errt_popcount: combinational count of set bits in an N-bit vector
// Ports: bits (N) in, count ($clog2(N+1)) out
module errt_popcount #(
  parameter int N = 48
) (
  input  logic [N-1:0]             bits,
  output logic [$clog2(N+1)-1:0]   count
);
  localparam int CW = $clog2(N+1);
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/error_tracker_trigger_ctrl.sv
// error_tracker_trigger_ctrl: decides when to pulse error_tracker.trigger from PRBS error flags
// Ports: clk, rstb (async, active low); prbs_flags, stored_frames, arm, disarm, mode,
//   err_threshold, holdoff, period, max_triggers in; trigger, armed, done,
//   trigger_count, missed_count out.
// Option: define ERRT_TRIG_MISSED_CNT_EN to count qualifying events dropped in HOLDOFF;
//   otherwise missed_count is tied to 0.
module error_tracker_trigger_ctrl
  import error_tracker_ctrl_pkg::*;
#(
  parameter int width     = 16,
  parameter int addrwidth = 12,
  parameter int cntwidth  = 16
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic [width*3-1:0]            prbs_flags,
  input  logic [addrwidth-1:0]          stored_frames,
  input  logic                          arm,
  input  logic                          disarm,
  input  logic [1:0]                    mode,
  input  logic [$clog2(width*3+1)-1:0]  err_threshold,
  input  logic [cntwidth-1:0]           holdoff,
  input  logic [cntwidth-1:0]           period,
  input  logic [addrwidth-1:0]          max_triggers,
  output logic                          trigger,
  output logic                          armed,
  output logic                          done,
  output logic [addrwidth-1:0]          trigger_count,
  output logic [cntwidth-1:0]           missed_count
);
  localparam int NF = width * 3;
  localparam int TW = $clog2(NF + 1);
  localparam logic [addrwidth-1:0] FULL_LIM = addrwidth'((1 << addrwidth) - 1 - STORE_BURST);
  localparam logic [cntwidth-1:0] HMIN = cntwidth'(MIN_HOLDOFF);
  localparam logic [cntwidth-1:0] PMIN = cntwidth'(MIN_PERIOD);
  trig_state_t state, state_nxt;
  trig_mode_t md;
  logic [TW-1:0] pop, thr;
  logic [cntwidth-1:0] hold_cnt, per_cnt, hlim, plim;
  logic qual, per_wrap, hold_end, spent, near_full, fire, restart;
  errt_popcount #(.N(NF)) u_pop (.bits(prbs_flags), .count(pop));
  assign md        = trig_mode_t'(mode);
  assign thr       = (err_threshold == '0) ? TW'(1) : err_threshold;
  assign hlim      = (holdoff < HMIN) ? HMIN : holdoff;
  assign plim      = (period < PMIN) ? PMIN : period;
  // >= rather than == so a live shrink of period/holdoff never strands the counter
  assign per_wrap  = per_cnt >= plim - 1'b1;
  assign hold_end  = hold_cnt >= hlim - 1'b1;
  assign spent     = (max_triggers != '0) && (trigger_count == max_triggers);
  assign near_full = stored_frames > FULL_LIM;
  assign qual      = (md == ANY_ERR) ? |prbs_flags :
                     (md == THRESH) ? (pop >= thr) :
                     (md == PERIODIC) ? per_wrap : 1'b0;
  assign restart   = arm && !disarm;
  assign armed     = (state == ARMED) || (state == HOLDOFF);
  assign done      = state == DONE;
  assign fire      = (state == ARMED) && (state_nxt == HOLDOFF);
  always_comb begin
    state_nxt = state;
    if (disarm) state_nxt = IDLE;
    else if (arm) state_nxt = ARMED;
    else if (state == ARMED) state_nxt = (spent || near_full) ? DONE : qual ? HOLDOFF : ARMED;
    else if (state == HOLDOFF) state_nxt = !hold_end ? HOLDOFF : (spent || near_full) ? DONE : ARMED;
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      trigger       <= 1'b0;
      trigger_count <= '0;
      hold_cnt      <= '0;
      per_cnt       <= '0;
    end else begin
      state    <= state_nxt;
      trigger  <= fire;
      hold_cnt <= (state == HOLDOFF && !hold_end) ? hold_cnt + 1'b1 : '0;
      if (restart) begin
        trigger_count <= '0;
        per_cnt       <= '0;
      end else begin
        if (fire) trigger_count <= trigger_count + 1'b1;
        if (armed) per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;
      end
    end
  end
`ifdef ERRT_TRIG_MISSED_CNT_EN
  // the first HOLDOFF cycle carries the trigger pulse itself, so it is not a drop
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) missed_count <= '0;
    else if (restart) missed_count <= '0;
    else if (state == HOLDOFF && qual && !trigger && !(&missed_count)) missed_count <= missed_count + 1'b1;
  end
`else
  assign missed_count = '0;
`endif
endmodule
